instr_fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register of the MIPS core. Holds the PC, requests

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/mips_instr_fields.sv | 32 +++
 rtl/instr_fetch_stage.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared fetch/decode types, field positions and opcode constants
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] c_reset_pc = 32'h0000_0000;
  localparam logic [31:0] c_pc_inc   = 32'd4;

  // Least-significant bit of each instruction field
  localparam int c_opcode_lsb = 26;
  localparam int c_rs_lsb     = 21;
  localparam int c_rt_lsb     = 16;
  localparam int c_rd_lsb     = 11;
  localparam int c_shamt_lsb  = 6;
  localparam int c_funct_lsb  = 0;
  localparam int c_imm_lsb    = 0;
  localparam int c_jaddr_lsb  = 0;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2b;

  localparam logic [5:0] c_fn_sll   = 6'h00;
  localparam logic [5:0] c_fn_jr    = 6'h08;
  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_and   = 6'h24;
  localparam logic [5:0] c_fn_or    = 6'h25;
  localparam logic [5:0] c_fn_slt   = 6'h2a;

endpackage

`default_nettype wire

// File: rtl/mips_instr_fields.sv
// ============================================================================
// mips_instr_fields : splits a 32-bit MIPS word into its decode fields
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_instr_fields
  import mips_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [5:0]  o_opcode,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic [5:0]  o_funct,
  output logic [15:0] o_imm,
  output logic [25:0] o_jaddr
);

  assign o_opcode = i_word[c_opcode_lsb +: 6];
  assign o_rs     = i_word[c_rs_lsb     +: 5];
  assign o_rt     = i_word[c_rt_lsb     +: 5];
  assign o_rd     = i_word[c_rd_lsb     +: 5];
  assign o_shamt  = i_word[c_shamt_lsb  +: 5];
  assign o_funct  = i_word[c_funct_lsb  +: 6];
  assign o_imm    = i_word[c_imm_lsb    +: 16];
  assign o_jaddr  = i_word[c_jaddr_lsb  +: 26];

endmodule

`default_nettype wire

// File: rtl/instr_fetch_stage.sv
// ============================================================================
// instr_fetch_stage : PC, instruction-memory req/ack fetch and IF/ID register
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc,
  parameter logic [31:0] PC_INC   = c_pc_inc
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic [5:0]  o_opcode,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic [5:0]  o_funct,
  output logic [15:0] o_imm,
  output logic [25:0] o_jaddr
);

  localparam logic [31:0] c_boot_pc = {RESET_PC[31:2], 2'b00};

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  r_addr;
  logic [31:0]  w_addr_next;
  logic [31:0]  r_instr;
  logic [31:0]  w_instr_next;
  logic [31:0]  r_pc_plus4;
  logic [31:0]  w_pc_plus4_next;
  logic         r_drop;
  logic         w_drop_next;
  logic         w_req;
  logic         w_ack;
  logic         w_fire;
  logic         w_load;

  // In S_FULL the next request is only launched when the slot is being drained
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_REQ:   w_req = 1'b1;
      S_FULL:  w_req = i_ready & ~i_redirect;
      default: w_req = 1'b0;
    endcase
    w_req = w_req & i_rst_n;
  end

  assign o_valid = (r_state == S_FULL);
  assign w_fire  = o_valid & i_ready;
  assign w_ack   = w_req & i_imem_ack;
  assign w_load  = w_ack & ~r_drop & ~i_redirect;

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_drop_next     = r_drop;
    w_instr_next    = r_instr;
    w_pc_plus4_next = r_pc_plus4;

    case (r_state)
      S_BOOT: w_state_next = S_REQ;
      S_REQ: begin
        if (w_ack) begin
          if (r_drop) begin
            w_drop_next = 1'b0;
          end else begin
            w_state_next = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (w_fire && !w_ack) begin
          w_state_next = S_REQ;
        end
      end
      default: w_state_next = S_BOOT;
    endcase

    if (w_load) begin
      w_instr_next    = i_imem_rdata;
      w_pc_plus4_next = r_addr + 32'd4;
      w_pc_next       = r_pc + PC_INC;
    end

    // Redirect overrides any ack/fire; an in-flight request must be absorbed later
    if (i_redirect) begin
      w_pc_next    = {i_redirect_pc[31:2], 2'b00};
      w_state_next = S_REQ;
      if (r_state == S_REQ && !w_ack) begin
        w_drop_next = 1'b1;
      end
    end
  end

  // The address is frozen while a request waits for its ack
  assign w_addr_next = (w_req && !w_ack) ? r_addr : w_pc_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_BOOT;
      r_pc       <= c_boot_pc;
      r_addr     <= c_boot_pc;
      r_instr    <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_addr     <= w_addr_next;
      r_instr    <= w_instr_next;
      r_pc_plus4 <= w_pc_plus4_next;
      r_drop     <= w_drop_next;
    end
  end

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_addr;
  assign o_instr     = r_instr;
  assign o_pc_plus4  = r_pc_plus4;

  mips_instr_fields u_fields (
    .i_word   (r_instr),
    .o_opcode (o_opcode),
    .o_rs     (o_rs),
    .o_rt     (o_rt),
    .o_rd     (o_rd),
    .o_shamt  (o_shamt),
    .o_funct  (o_funct),
    .o_imm    (o_imm),
    .o_jaddr  (o_jaddr)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
// ============================================================================
// tb_instr_fetch_stage : scoreboard bench for instr_fetch_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        force_ack = 1'b0;

  logic        imem_req, imem_ack, valid;
  logic [31:0] imem_addr, imem_rdata, instr, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] jaddr;

  logic        req2, ack2, valid2;
  logic [31:0] addr2, rdata2, instr2, pcp2;
  logic [5:0]  opcode2, funct2;
  logic [4:0]  rs2, rt2, rd2, shamt2;
  logic [15:0] imm2;
  logic [25:0] jaddr2;

  int n_vec = 0;
  int n_err = 0;
  int wait_left = 0;
  int min_delay = 0;
  int max_delay = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h2008_8005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: ack after a random number of wait cycles, plus forced acks
  assign imem_ack   = (imem_req && wait_left == 0) || force_ack;
  assign imem_rdata = mem_word(imem_addr);
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_left <= int'($urandom_range(max_delay, min_delay));
    else if (wait_left > 0)    wait_left <= wait_left - 1;
  end

  assign ack2   = req2;
  assign rdata2 = mem_word(addr2);

  instr_fetch_stage #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_valid(valid), .i_ready(ready), .o_instr(instr),
    .o_pc_plus4(pc_plus4), .o_opcode(opcode), .o_rs(rs), .o_rt(rt), .o_rd(rd),
    .o_shamt(shamt), .o_funct(funct), .o_imm(imm), .o_jaddr(jaddr)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(32'd4)) u_dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_ack(ack2), .i_imem_rdata(rdata2), .i_redirect(1'b0),
    .i_redirect_pc(32'h0), .o_valid(valid2), .i_ready(ready), .o_instr(instr2),
    .o_pc_plus4(pcp2), .o_opcode(opcode2), .o_rs(rs2), .o_rt(rt2), .o_rd(rd2),
    .o_shamt(shamt2), .o_funct(funct2), .o_imm(imm2), .o_jaddr(jaddr2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the in-order stream of fetch addresses the core should deliver
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  task automatic topup();
    while (exp_q.size() < 8) begin
      last_exp = last_exp + 32'd4;
      exp_q.push_back(last_exp);
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    last_exp = {a[31:2], 2'b00};
    exp_q.push_back(last_exp);
    topup();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n)        restart(32'h0000_0000);
    else if (redirect) restart(redirect_pc);
    else               topup();
    #1;
  endtask

  // Monitor: pops one expected entry per accepted slot, checks request hold
  logic        prev_out = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int          idle_cnt = 0;
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] w;
    if (rst_n) begin
      if (prev_out) begin
        chk("req_held", imem_req, 1'b1);
        chk("addr_held", imem_addr, prev_addr);
      end
      if (imem_req) chk("addr_align", imem_addr[1:0], 2'b00);
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          w = mem_word(e);
          chk("instr", instr, w);
          chk("pc_plus4", pc_plus4, e + 32'd4);
          chk("opcode", opcode, w[31:26]);
          chk("rs", rs, w[25:21]);
          chk("rt", rt, w[20:16]);
          chk("rd_shamt_funct", {rd, shamt, funct}, w[15:0]);
          chk("imm", imm, w[15:0]);
          chk("jaddr", jaddr, w[25:0]);
        end
        idle_cnt <= 0;
      end else if (ready && !redirect) begin
        if (idle_cnt > 40) begin
          chk("progress_timeout", 1'b0, 1'b1);
          idle_cnt <= 0;
        end else begin
          idle_cnt <= idle_cnt + 1;
        end
      end
    end
    prev_out  <= rst_n & imem_req & ~imem_ack;
    prev_addr <= imem_addr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen40;
    logic got;
    restart(32'h0);

    // Reset and zero-wait streaming
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pcp4", pc_plus4, 32'h0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    tick(); rst_n = 1'b1; ready = 1'b1;
    @(negedge clk);
    chk("boot_req", imem_req, 1'b0);
    chk("boot_valid", valid, 1'b0);
    tick(); @(negedge clk);
    chk("req0", imem_req, 1'b1);
    chk("addr0", imem_addr, 32'h0);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    tick(); @(negedge clk);
    chk("valid3", valid, 1'b1);
    chk("pcp4_a", pc_plus4, 32'h4);
    chk("addr4", imem_addr, 32'h4);
    chk("wrap_pcp4_a", pcp2, 32'h0);
    chk("wrap_addr1", addr2, 32'h0);
    tick(); @(negedge clk);
    chk("pcp4_b", pc_plus4, 32'h8);
    chk("addr8", imem_addr, 32'h8);
    chk("wrap_pcp4_b", pcp2, 32'h4);
    tick(); @(negedge clk);
    chk("pcp4_c", pc_plus4, 32'hC);
    chk("addrC", imem_addr, 32'hC);

    // Field split of 0x2008_8005 and hold while not ready
    tick(); redirect = 1'b1; redirect_pc = 32'h200;
    tick(); redirect = 1'b0; ready = 1'b0;
    tick(); @(negedge clk);
    chk("f_valid", valid, 1'b1);
    chk("f_opcode", opcode, 6'h08);
    chk("f_rs", rs, 5'd0);
    chk("f_rt", rt, 5'd8);
    chk("f_imm", imm, 16'h8005);
    chk("f_pcp4", pc_plus4, 32'h204);
    min_delay = 3; max_delay = 3;
    repeat (5) begin
      tick(); @(negedge clk);
      chk("hold_req", imem_req, 1'b0);
      chk("hold_valid", valid, 1'b1);
      chk("hold_instr", instr, 32'h2008_8005);
    end

    // Three-cycle ack delay
    tick(); ready = 1'b1;
    @(negedge clk);
    chk("dly_req_a", {imem_req, imem_ack}, 2'b10);
    chk("dly_addr_a", imem_addr, 32'h204);
    tick(); ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("dly_req_w", {imem_req, imem_ack}, 2'b10);
      chk("dly_addr_w", imem_addr, 32'h204);
      tick();
    end
    @(negedge clk);
    chk("dly_ack", {imem_req, imem_ack}, 2'b11);
    tick(); @(negedge clk);
    chk("dly_valid", valid, 1'b1);
    chk("dly_instr", instr, mem_word(32'h204));
    chk("dly_pcp4", pc_plus4, 32'h208);

    // Redirect while the request to 0x10 is outstanding
    tick(); redirect = 1'b1; redirect_pc = 32'h10;
    tick(); redirect = 1'b0;
    @(negedge clk);
    chk("drop_req10", {imem_req, imem_ack}, 2'b10);
    chk("drop_addr10", imem_addr, 32'h10);
    tick(); redirect = 1'b1; redirect_pc = 32'h43;
    @(negedge clk);
    chk("drop_addr_held", imem_addr, 32'h10);
    tick(); redirect = 1'b0; ready = 1'b1;
    seen40 = 1'b0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h40) seen40 = 1'b1;
      if (valid) begin
        chk("drop_first_pcp4", pc_plus4, 32'h44);
        chk("drop_first_instr", instr, mem_word(32'h40));
        got = 1'b1;
      end
      tick();
    end
    chk("drop_refetch40", seen40, 1'b1);
    chk("drop_done", got, 1'b1);

    // Redirect, ack and ready in one cycle
    min_delay = 0; max_delay = 0;
    repeat (6) tick();
    redirect = 1'b1; redirect_pc = 32'h300; force_ack = 1'b1;
    @(negedge clk);
    chk("same_pre_valid", valid, 1'b1);
    tick(); redirect = 1'b0; force_ack = 1'b0;
    @(negedge clk);
    chk("same_valid", valid, 1'b0);
    chk("same_req", imem_req, 1'b1);
    chk("same_addr", imem_addr, 32'h300);
    tick(); @(negedge clk);
    chk("same_next_valid", valid, 1'b1);
    chk("same_next_pcp4", pc_plus4, 32'h304);

    // Reset in the middle of a wait
    min_delay = 3; max_delay = 3;
    tick(); tick();
    @(negedge clk);
    chk("rw_outstanding", {imem_req, imem_ack}, 2'b10);
    tick(); rst_n = 1'b0;
    @(negedge clk);
    chk("rw_req_drop", imem_req, 1'b0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("rw_boot_req", imem_req, 1'b0);
    chk("rw_boot_valid", valid, 1'b0);
    tick(); @(negedge clk);
    chk("rw_restart_req", imem_req, 1'b1);
    chk("rw_restart_addr", imem_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      case ((i / 500) % 3)
        0:       begin min_delay = 0; max_delay = 0; end
        1:       begin min_delay = 0; max_delay = 2; end
        default: begin min_delay = 0; max_delay = 3; end
      endcase
      rst_n     = ($urandom_range(999, 0) != 0);
      ready     = ($urandom_range(3, 0) != 0);
      redirect  = ($urandom_range(19, 0) == 0);
      force_ack = ($urandom_range(19, 0) == 0);
      if ($urandom_range(7, 0) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      else                           redirect_pc = $urandom & 32'h0000_FFFF;
    end

    rst_n = 1'b1; ready = 1'b1; redirect = 1'b0; force_ack = 1'b0;
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
